// File: rtl/wishbone_config_loader_if.sv
// Bundles the configuration-word stream and the Wishbone initiator bus of the loader.
// The master modport is the loader's view; the slave modport is the source/responder side.
interface wishbone_config_loader_if;
    logic [31:0] cfg_data_i;
    logic        cfg_valid_i;
    logic        cfg_last_i;
    logic        cfg_ready_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  cfg_data_i,
        input  cfg_valid_i,
        input  cfg_last_i,
        output cfg_ready_o,
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_we_o,
        output wbm_sel_o,
        output wbm_adr_o,
        output wbm_dat_o,
        input  wbm_dat_i,
        input  wbm_ack_i
    );

    modport slave (
        output cfg_data_i,
        output cfg_valid_i,
        output cfg_last_i,
        input  cfg_ready_o,
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_we_o,
        input  wbm_sel_o,
        input  wbm_adr_o,
        input  wbm_dat_o,
        output wbm_dat_i,
        output wbm_ack_i
    );
endinterface

// File: rtl/wishbone_config_loader.sv
// Wishbone initiator that writes streamed words to the configurator DATA register,
// then commits via CTRL and polls STATUS until the configurator reports idle.
module wishbone_config_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned POLL_GAP    = 8
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    wishbone_config_loader_if.master        wb,
    input  logic                            abort_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    output logic [15:0]                     word_count_o
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_CMT,
        ST_GAP,
        ST_RD_STAT,
        ST_DONE
    } state_t;

    localparam logic [31:0] ADR_DATA = BASE_ADDR;
    localparam logic [31:0] ADR_CTRL = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADR_STAT = BASE_ADDR + 32'h8;
    localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    state_t      r_state, w_state_nxt;
    logic        r_cyc, w_cyc_nxt;
    logic        r_we, w_we_nxt;
    logic [3:0]  r_sel;
    logic [31:0] r_adr, w_adr_nxt;
    logic [31:0] r_dat, w_dat_nxt;
    logic [15:0] r_gap_cnt, w_gap_cnt_nxt;
    logic [15:0] r_to_cnt;
    logic [15:0] r_word_cnt;
    logic        r_last;
    logic        r_ready_en;
    logic        r_err;

    logic        w_ready;
    logic        w_accept;
    logic        w_ack;
    logic        w_timeout;
    logic        w_unused_dat;

    assign w_ready      = r_ready_en && (r_state == ST_IDLE) && !abort_i;
    assign w_accept     = w_ready && wb.cfg_valid_i;
    assign w_ack        = r_cyc && wb.wbm_ack_i;
    // Counter holds cycles already elapsed, so an ack in cycle ACK_TIMEOUT still wins.
    assign w_timeout    = r_cyc && !wb.wbm_ack_i && (r_to_cnt == TO_LAST);
    assign w_unused_dat = ^wb.wbm_dat_i[31:1];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        w_state_nxt   = r_state;
        w_cyc_nxt     = r_cyc;
        w_we_nxt      = r_we;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_gap_cnt_nxt = r_gap_cnt;

        if (abort_i || w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_cyc_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = ST_WR_DATA;
                        w_cyc_nxt   = 1'b1;
                        w_we_nxt    = 1'b1;
                        w_adr_nxt   = ADR_DATA;
                        w_dat_nxt   = wb.cfg_data_i;
                    end
                end
                ST_WR_DATA: begin
                    if (w_ack) begin
                        w_cyc_nxt   = 1'b0;
                        w_state_nxt = r_last ? ST_WR_CMT : ST_IDLE;
                    end
                end
                ST_WR_CMT: begin
                    // Entered with cyc low, which provides the idle cycle after the data write.
                    if (!r_cyc) begin
                        w_cyc_nxt = 1'b1;
                        w_we_nxt  = 1'b1;
                        w_adr_nxt = ADR_CTRL;
                        w_dat_nxt = 32'h1;
                    end else if (w_ack) begin
                        w_cyc_nxt     = 1'b0;
                        w_gap_cnt_nxt = 16'd0;
                        w_state_nxt   = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_state_nxt = ST_RD_STAT;
                        w_cyc_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_adr_nxt   = ADR_STAT;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 16'd1;
                    end
                end
                ST_RD_STAT: begin
                    if (w_ack) begin
                        w_cyc_nxt = 1'b0;
                        if (wb.wbm_dat_i[0]) begin
                            w_gap_cnt_nxt = 16'd0;
                            w_state_nxt   = ST_GAP;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state    <= ST_IDLE;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_adr      <= 32'h0;
            r_dat      <= 32'h0;
            r_gap_cnt  <= 16'd0;
            r_to_cnt   <= 16'd0;
            r_word_cnt <= 16'd0;
            r_last     <= 1'b0;
            r_ready_en <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_we       <= w_cyc_nxt && w_we_nxt;
            r_sel      <= w_cyc_nxt ? 4'hF : 4'h0;
            r_adr      <= w_adr_nxt;
            r_dat      <= w_dat_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_ready_en <= 1'b1;
            r_to_cnt   <= r_cyc ? r_to_cnt + 16'd1 : 16'd0;

            if (w_accept) begin
                r_last <= wb.cfg_last_i;
            end

            if (abort_i || w_timeout || (r_state == ST_DONE)) begin
                r_word_cnt <= 16'd0;
            end else if (w_accept && (r_word_cnt != 16'hFFFF)) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end

            // Abort takes precedence over a coincident timeout and leaves err untouched.
            if (w_timeout && !abort_i) begin
                r_err <= 1'b1;
            end else if (w_accept) begin
                r_err <= 1'b0;
            end
        end
    end

    assign wb.cfg_ready_o = w_ready;
    assign wb.wbm_cyc_o   = r_cyc;
    assign wb.wbm_stb_o   = r_cyc;
    assign wb.wbm_we_o    = r_we;
    assign wb.wbm_sel_o   = r_sel;
    assign wb.wbm_adr_o   = r_adr;
    assign wb.wbm_dat_o   = r_dat;

    assign busy_o       = (r_state != ST_IDLE) || (r_word_cnt != 16'd0);
    assign done_o       = (r_state == ST_DONE);
    assign err_o        = r_err;
    assign word_count_o = r_word_cnt;
endmodule

// File: tb/tb_wishbone_config_loader.sv
// Directed and randomized bench for wishbone_config_loader: a Wishbone responder model
// logs every transaction and each load is compared with the sequence the rules predict.
module tb_wishbone_config_loader;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TO   = 4;
    localparam int          GAP  = 3;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          start_c;
        int          end_c;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] wc;

    wishbone_config_loader_if bus();

    wishbone_config_loader #(
        .BASE_ADDR   (BASE),
        .ACK_TIMEOUT (TO),
        .POLL_GAP    (GAP)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wb           (bus),
        .abort_i      (abort),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .word_count_o (wc)
    );

    int          checks;
    int          errors;
    int          cycle;
    txn_t        log_q[$];
    logic [31:0] ld_words[$];
    int          ack_lat;
    bit          withhold;
    bit          abort_on_cmt;
    logic        stat_arr[0:63];
    int          stat_wr;
    int          stat_rd;
    int          done_cnt;
    logic [15:0] wc_at_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Responder: acks the ack_lat-th strobe cycle; STATUS reads return queued busy bits.
    initial begin : responder
        int   stb_cycles;
        int   start_c;
        txn_t t;
        stb_cycles    = 0;
        start_c       = 0;
        stat_rd       = 0;
        abort         = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            abort         = 1'b0;
            bus.wbm_ack_i = 1'b0;
            if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                if (stb_cycles == 0) start_c = cycle;
                stb_cycles++;
                if (!withhold && stb_cycles == ack_lat) begin
                    bus.wbm_ack_i = 1'b1;
                    if (bus.wbm_we_o) begin
                        bus.wbm_dat_i = $urandom;
                    end else if (stat_rd < stat_wr) begin
                        bus.wbm_dat_i = {31'($urandom), stat_arr[stat_rd % 64]};
                        stat_rd++;
                    end else begin
                        bus.wbm_dat_i = {31'($urandom), 1'b0};
                    end
                    t.we      = bus.wbm_we_o;
                    t.adr     = bus.wbm_adr_o;
                    t.dat     = bus.wbm_dat_o;
                    t.sel     = bus.wbm_sel_o;
                    t.start_c = start_c;
                    t.end_c   = cycle;
                    log_q.push_back(t);
                    if (abort_on_cmt && bus.wbm_we_o && bus.wbm_adr_o == BASE + 32'h4) abort = 1'b1;
                end
            end else begin
                stb_cycles = 0;
            end
        end
    end

    initial begin : done_monitor
        done_cnt   = 0;
        wc_at_done = 16'h0;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                wc_at_done = wc;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit is_last);
        int n;
        bus.cfg_data_i  = w;
        bus.cfg_last_i  = is_last;
        bus.cfg_valid_i = 1'b1;
        n = 0;
        while (!bus.cfg_ready_o && n < 200) begin
            tick();
            n++;
        end
        check("accept_wait", n < 200, 1);
        tick();
        bus.cfg_valid_i = 1'b0;
        bus.cfg_last_i  = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 600) begin
            tick();
            n++;
        end
        check({tag, "/idle_wait"}, n < 600, 1);
    endtask

    // Reference: one DATA write per word, one CTRL commit, then busy_reads+1 STATUS reads.
    task automatic compare_log(input string tag, input int base, input int busy_reads);
        txn_t exp_q[$];
        txn_t e;
        txn_t o;
        int   idle;
        int   min_idle;
        e.sel = 4'hF; e.start_c = 0; e.end_c = 0;
        foreach (ld_words[i]) begin
            e.we = 1'b1; e.adr = BASE; e.dat = ld_words[i];
            exp_q.push_back(e);
        end
        e.we = 1'b1; e.adr = BASE + 32'h4; e.dat = 32'h1;
        exp_q.push_back(e);
        for (int r = 0; r <= busy_reads; r++) begin
            e.we = 1'b0; e.adr = BASE + 32'h8; e.dat = 32'h0;
            exp_q.push_back(e);
        end
        check({tag, "/txn_count"}, log_q.size() - base, exp_q.size());
        for (int j = 0; j < exp_q.size() && base + j < log_q.size(); j++) begin
            o = log_q[base + j];
            check($sformatf("%s/txn%0d", tag, j),
                  {o.we, o.adr, (o.we ? o.dat : 32'h0), o.sel},
                  {exp_q[j].we, exp_q[j].adr, exp_q[j].dat, exp_q[j].sel});
            if (j > 0) begin
                idle     = o.start_c - log_q[base + j - 1].end_c - 1;
                min_idle = o.we ? 1 : GAP;
                check($sformatf("%s/gap%0d", tag, j), idle >= min_idle, 1);
            end
        end
    endtask

    task automatic run_load(input string tag, input int busy_reads, input int lat);
        int base;
        int d0;
        int nwords;
        ack_lat = lat;
        nwords  = ld_words.size();
        for (int i = 0; i < busy_reads; i++) begin
            stat_arr[stat_wr % 64] = 1'b1;
            stat_wr++;
        end
        stat_arr[stat_wr % 64] = 1'b0;
        stat_wr++;
        base = log_q.size();
        d0   = done_cnt;
        for (int i = 0; i < nwords; i++) begin
            send_word(ld_words[i], i == nwords - 1);
            if (i == 0) check({tag, "/err_clear"}, err, 0);
        end
        wait_not_busy(tag);
        check({tag, "/done_pulses"}, done_cnt - d0, 1);
        check({tag, "/wc_at_done"}, wc_at_done, nwords);
        check({tag, "/wc_after"}, wc, 0);
        check({tag, "/err"}, err, 0);
        compare_log(tag, base, busy_reads);
    endtask

    task automatic random_words(input int n);
        ld_words.delete();
        for (int i = 0; i < n; i++) ld_words.push_back($urandom);
    endtask

    initial begin : main
        int base;
        int d0;
        int n;
        checks          = 0;
        errors          = 0;
        stat_wr         = 0;
        ack_lat         = 1;
        withhold        = 1'b0;
        abort_on_cmt    = 1'b0;
        bus.cfg_data_i  = 32'h0;
        bus.cfg_valid_i = 1'b0;
        bus.cfg_last_i  = 1'b0;
        rst_n           = 1'b0;

        #12;
        check("reset_outputs",
              {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
               bus.wbm_dat_o, bus.cfg_ready_o, busy, done, err, wc}, 128'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", bus.cfg_ready_o, 1);

        // Three words, ack after one cycle, STATUS idle on the first read.
        ld_words.delete();
        ld_words.push_back(32'hA5A5_0001);
        ld_words.push_back(32'h5A5A_0002);
        ld_words.push_back(32'hDEAD_BEEF);
        run_load("basic3", 0, 1);

        // STATUS returns busy, busy, idle.
        random_words(2);
        run_load("poll3", 2, 1);

        // Ack withheld: cyc must drop after ACK_TIMEOUT cycles with err set.
        withhold = 1'b1;
        send_word($urandom, 1'b0);
        n = 0;
        while (bus.wbm_cyc_o && n < 20) begin
            n++;
            tick();
        end
        check("timeout/cyc_cycles", n, TO);
        check("timeout/err", err, 1);
        check("timeout/wc", wc, 0);
        check("timeout/idle", {busy, bus.cfg_ready_o}, 2'b01);
        withhold = 1'b0;

        // Next accepted word clears err.
        random_words(1);
        run_load("err_clear", 0, 2);

        // Ack on exactly the timeout cycle is accepted.
        random_words(2);
        run_load("ack_on_limit", 1, TO);

        // Abort coincident with the commit ack.
        ack_lat      = 1;
        abort_on_cmt = 1'b1;
        base         = log_q.size();
        d0           = done_cnt;
        send_word(32'h1111_2222, 1'b0);
        send_word(32'h3333_4444, 1'b1);
        n = 0;
        while (!abort && n < 50) begin
            tick();
            n++;
        end
        check("abort/seen", n < 50, 1);
        tick();
        check("abort/state", {bus.wbm_cyc_o, bus.cfg_ready_o, busy, err, wc}, {1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        abort_on_cmt = 1'b0;
        repeat (20) tick();
        check("abort/no_done", done_cnt - d0, 0);
        check("abort/txn_count", log_q.size() - base, 3);

        // Randomized loads: length, data, poll count and ack latency.
        for (int k = 0; k < 6; k++) begin
            random_words($urandom_range(1, 5));
            run_load($sformatf("rand%0d", k), $urandom_range(0, 2), $urandom_range(1, TO));
        end

        // Reset asserted mid WR_DATA.
        withhold = 1'b1;
        send_word($urandom, 1'b0);
        check("rst_mid/in_txn", bus.wbm_cyc_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid/outputs",
              {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
               bus.wbm_dat_o, bus.cfg_ready_o, busy, done, err, wc}, 128'h0);
        withhold = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid/recover", {bus.cfg_ready_o, bus.wbm_cyc_o, busy}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
